// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter between the ALU and the memory unit. Each source
//   feeds a small circular FIFO; one result per cycle is granted onto the
//   registered broadcast bus (cdb_*). When both sources have a candidate, the
//   grant goes to the source that did not win last time (round robin).
//
//   Optional feature macro: CDB_BYPASS_EN
//     defined   - a result arriving at an empty FIFO competes in the same
//                 cycle (minimum latency 1 cycle)
//     undefined - every result is pushed first; arbitration sees FIFO heads
//                 only (minimum latency 2 cycles)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush                      synchronous mispredict flush
//   alu_ready/alu_res/alu_id   ALU result input
//   alu_stall                  ALU FIFO full
//   mem_ready/mem_res/mem_id   load result input
//   mem_stall                  memory FIFO full
//   cdb_ready/cdb_val/cdb_id   registered broadcast
//   cdb_src                    broadcast source: 0 = ALU, 1 = memory
//   cdb_overflow               sticky: a push was attempted while stalled

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module cdb_arbiter #(
   parameter int unsigned DATA_WIDTH = `XLEN,
   parameter int unsigned ID_WIDTH   = `ROB_SIZE_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  alu_ready,
   input  logic [DATA_WIDTH-1:0] alu_res,
   input  logic [ID_WIDTH-1:0]   alu_id,
   output logic                  alu_stall,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_res,
   input  logic [ID_WIDTH-1:0]   mem_id,
   output logic                  mem_stall,
   output logic                  cdb_ready,
   output logic [DATA_WIDTH-1:0] cdb_val,
   output logic [ID_WIDTH-1:0]   cdb_id,
   output logic                  cdb_src,
   output logic                  cdb_overflow
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

`ifdef CDB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   // Index 0 = ALU, index 1 = memory throughout.
   logic [PW-1:0]         r_rptr [2];
   logic [PW-1:0]         r_wptr [2];
   logic [CW-1:0]         r_cnt  [2];
   logic [DATA_WIDTH-1:0] r_fdata [2][FIFO_DEPTH];
   logic [ID_WIDTH-1:0]   r_fid   [2][FIFO_DEPTH];

   logic                  r_last_grant;
   logic                  r_cdb_ready;
   logic [DATA_WIDTH-1:0] r_cdb_val;
   logic [ID_WIDTH-1:0]   r_cdb_id;
   logic                  r_cdb_src;
   logic                  r_overflow;

   logic [1:0]            w_in_rdy;
   logic [DATA_WIDTH-1:0] w_in_data [2];
   logic [ID_WIDTH-1:0]   w_in_id   [2];

   logic [1:0]            w_stall;
   logic [1:0]            w_empty;
   logic [1:0]            w_byp;
   logic [1:0]            w_cand;
   logic [DATA_WIDTH-1:0] w_cand_data [2];
   logic [ID_WIDTH-1:0]   w_cand_id   [2];

   logic                  w_gnt_v;
   logic                  w_gnt_src;
   logic [1:0]            w_gnt;
   logic [1:0]            w_push;
   logic [1:0]            w_pop;

   assign w_in_rdy     = {mem_ready, alu_ready};
   assign w_in_data[0] = alu_res;
   assign w_in_data[1] = mem_res;
   assign w_in_id[0]   = alu_id;
   assign w_in_id[1]   = mem_id;

   // Per-source status and candidate selection
   always_comb begin
      for (int unsigned s = 0; s < 2; s++) begin
         w_stall[s]     = (r_cnt[s] == CW'(FIFO_DEPTH));
         w_empty[s]     = (r_cnt[s] == '0);
         w_byp[s]       = BYP && w_empty[s] && w_in_rdy[s];
         w_cand[s]      = !w_empty[s] || w_byp[s];
         w_cand_data[s] = w_empty[s] ? w_in_data[s] : r_fdata[s][r_rptr[s]];
         w_cand_id[s]   = w_empty[s] ? w_in_id[s]   : r_fid[s][r_rptr[s]];
      end
   end

   // Round robin: on contention the source that did not win last time wins
   always_comb begin
      w_gnt_v   = |w_cand;
      w_gnt_src = (&w_cand) ? ~r_last_grant : w_cand[1];
      w_gnt     = '0;
      if (w_gnt_v && !flush)
         w_gnt[w_gnt_src] = 1'b1;
   end

   // A bypassed result that wins goes straight to the bus and is never stored;
   // a stalled push is dropped (and flagged), a flush-cycle push is discarded.
   always_comb begin
      for (int unsigned s = 0; s < 2; s++) begin
         w_push[s] = w_in_rdy[s] && !w_stall[s] && !flush && !(w_byp[s] && w_gnt[s]);
         w_pop[s]  = w_gnt[s] && !w_empty[s];
      end
   end

   // FIFO pointers and counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < 2; s++) begin
            r_rptr[s] <= '0;
            r_wptr[s] <= '0;
            r_cnt[s]  <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < 2; s++) begin
            if (flush) begin
               r_rptr[s] <= '0;
               r_wptr[s] <= '0;
               r_cnt[s]  <= '0;
            end else begin
               if (w_push[s])
                  r_wptr[s] <= r_wptr[s] + PW'(1);
               if (w_pop[s])
                  r_rptr[s] <= r_rptr[s] + PW'(1);
               r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            end
         end
      end
   end

   // FIFO storage carries no reset; validity is tracked by the counts
   always_ff @(posedge clk) begin
      for (int unsigned s = 0; s < 2; s++) begin
         if (w_push[s]) begin
            r_fdata[s][r_wptr[s]] <= w_in_data[s];
            r_fid[s][r_wptr[s]]   <= w_in_id[s];
         end
      end
   end

   // Broadcast register, arbitration history and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cdb_ready  <= 1'b0;
         r_cdb_val    <= '0;
         r_cdb_id     <= '0;
         r_cdb_src    <= 1'b0;
         r_last_grant <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (|(w_in_rdy & w_stall))
            r_overflow <= 1'b1;
         if (flush) begin
            r_cdb_ready  <= 1'b0;
            r_last_grant <= 1'b0;
         end else if (w_gnt_v) begin
            r_cdb_ready  <= 1'b1;
            r_cdb_val    <= w_cand_data[w_gnt_src];
            r_cdb_id     <= w_cand_id[w_gnt_src];
            r_cdb_src    <= w_gnt_src;
            r_last_grant <= w_gnt_src;
         end else begin
            r_cdb_ready  <= 1'b0;
         end
      end
   end

   assign alu_stall    = w_stall[0];
   assign mem_stall    = w_stall[1];
   assign cdb_ready    = r_cdb_ready;
   assign cdb_val      = r_cdb_val;
   assign cdb_id       = r_cdb_id;
   assign cdb_src      = r_cdb_src;
   assign cdb_overflow = r_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter: every accepted result is queued per
//   source when driven and popped/compared when it appears on the bus.
//   Cross-source order is checked separately from a log of granted sources.

`timescale 1ns/1ps

module tb_cdb_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;
   localparam int unsigned FD = 4;

`ifdef CDB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   typedef logic [IW+DW-1:0] ent_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          alu_ready = 1'b0;
   logic [DW-1:0] alu_res = '0;
   logic [IW-1:0] alu_id = '0;
   logic          alu_stall;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_res = '0;
   logic [IW-1:0] mem_id = '0;
   logic          mem_stall;
   logic          cdb_ready;
   logic [DW-1:0] cdb_val;
   logic [IW-1:0] cdb_id;
   logic          cdb_src;
   logic          cdb_overflow;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   ent_t q_alu[$];
   ent_t q_mem[$];
   logic q_log[$];

   cdb_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id), .alu_stall(alu_stall),
      .mem_ready(mem_ready), .mem_res(mem_res), .mem_id(mem_id), .mem_stall(mem_stall),
      .cdb_ready(cdb_ready), .cdb_val(cdb_val), .cdb_id(cdb_id), .cdb_src(cdb_src),
      .cdb_overflow(cdb_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      ent_t e;
      if (rst_n && cdb_ready) begin
         q_log.push_back(cdb_src);
         if (!cdb_src) begin
            chk("alu_sb_avail", 64'(q_alu.size() != 0), 64'd1);
            if (q_alu.size() != 0) begin
               e = q_alu.pop_front();
               chk("alu_id", 64'(cdb_id), 64'(e[IW+DW-1:DW]));
               chk("alu_val", 64'(cdb_val), 64'(e[DW-1:0]));
            end
         end else begin
            chk("mem_sb_avail", 64'(q_mem.size() != 0), 64'd1);
            if (q_mem.size() != 0) begin
               e = q_mem.pop_front();
               chk("mem_id", 64'(cdb_id), 64'(e[IW+DW-1:DW]));
               chk("mem_val", 64'(cdb_val), 64'(e[DW-1:0]));
            end
         end
      end
   end

   task automatic idle_inputs();
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      q_alu.delete();
      q_mem.delete();
      q_log.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      int unsigned cyc = 0;
      while ((q_alu.size() != 0 || q_mem.size() != 0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk({tag, "_alu_left"}, 64'(q_alu.size()), 64'd0);
      chk({tag, "_mem_left"}, 64'(q_mem.size()), 64'd0);
   endtask

   task automatic drive_alu(input logic [IW-1:0] id, input logic [DW-1:0] v, input logic expect_ok);
      alu_ready = 1'b1;
      alu_id    = id;
      alu_res   = v;
      if (expect_ok) q_alu.push_back({id, v});
   endtask

   task automatic drive_mem(input logic [IW-1:0] id, input logic [DW-1:0] v, input logic expect_ok);
      mem_ready = 1'b1;
      mem_id    = id;
      mem_res   = v;
      if (expect_ok) q_mem.push_back({id, v});
   endtask

   initial begin
      logic        seen_as;
      logic        seen_ms;
      logic        ovf_done;
      int unsigned k;
      logic [IW-1:0] ida;
      logic [IW-1:0] idm;

      // ---- reset values ----
      #2;
      chk("rst_ready", 64'(cdb_ready), 64'd0);
      chk("rst_val", 64'(cdb_val), 64'd0);
      chk("rst_id", 64'(cdb_id), 64'd0);
      chk("rst_src", 64'(cdb_src), 64'd0);
      chk("rst_ovf", 64'(cdb_overflow), 64'd0);
      chk("rst_stall", 64'({alu_stall, mem_stall}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- single result latency ----
      @(negedge clk);
      drive_alu(5'd3, 32'h0000_00AA, 1'b1);
      @(negedge clk);
      idle_inputs();
      chk("lat_c1", 64'(cdb_ready), 64'(BYP));
      @(negedge clk);
      chk("lat_c2", 64'(cdb_ready), 64'(!BYP));
      @(negedge clk);
      chk("lat_c3", 64'(cdb_ready), 64'd0);
      wait_drain("single");
      chk("single_log", 64'(q_log.size()), 64'd1);

      // ---- contention right after reset: last_grant=0 so memory wins first ----
      do_reset();
      @(negedge clk);
      drive_alu(5'd1, 32'h11, 1'b1);
      drive_mem(5'd2, 32'h22, 1'b1);
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);
      chk("cont_cnt", 64'(q_log.size()), 64'd2);
      if (q_log.size() == 2) begin
         chk("cont_first", 64'(q_log[0]), 64'd1);
         chk("cont_second", 64'(q_log[1]), 64'd0);
      end
      wait_drain("cont");

      // ---- saturation, stall and overflow ----
      q_log.delete();
      seen_as  = 1'b0;
      seen_ms  = 1'b0;
      ovf_done = 1'b0;
      ida = 5'd0;
      idm = 5'd16;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         idle_inputs();
         seen_as = seen_as | alu_stall;
         seen_ms = seen_ms | mem_stall;
         if (!alu_stall) begin
            drive_alu(ida, $urandom, 1'b1);
            ida++;
         end
         if (!mem_stall) begin
            drive_mem(idm, $urandom, 1'b1);
            idm++;
         end else if (!ovf_done) begin
            // dropped result: never queued, must never broadcast
            drive_mem(5'd31, 32'hDEAD_BEEF, 1'b0);
            ovf_done = 1'b1;
         end
      end
      @(negedge clk);
      idle_inputs();
      k = q_log.size();
      chk("alu_stall_seen", 64'(seen_as), 64'd1);
      chk("mem_stall_seen", 64'(seen_ms), 64'd1);
      chk("ovf_attempted", 64'(ovf_done), 64'd1);
      chk("ovf_set", 64'(cdb_overflow), 64'd1);
      for (int i = 1; i < int'(k); i++)
         chk("alternate", 64'(q_log[i] != q_log[i-1]), 64'd1);
      wait_drain("sat");

      // ---- flush with buffered entries ----
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_alu(5'(8 + i), 32'h100 + 32'(i), 1'b1);
         drive_mem(5'(12 + i), 32'h200 + 32'(i), 1'b1);
      end
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      drive_alu(5'd30, 32'hBAD0_0001, 1'b0);
      @(posedge clk);
      #1;
      q_alu.delete();
      q_mem.delete();
      @(negedge clk);
      idle_inputs();
      q_log.delete();
      chk("flush_ready", 64'(cdb_ready), 64'd0);
      chk("flush_stalls", 64'({alu_stall, mem_stall}), 64'd0);
      repeat (6) @(negedge clk);
      chk("flush_no_stale", 64'(q_log.size()), 64'd0);
      drive_alu(5'd7, 32'h77, 1'b1);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("fresh_cnt", 64'(q_log.size()), 64'd1);
      if (q_log.size() != 0)
         chk("fresh_src", 64'(q_log[0]), 64'd0);
      wait_drain("flush");

      // ---- overflow survives flush, clears on reset ----
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         idle_inputs();
         if (!alu_stall) drive_alu(5'(i), 32'h300 + 32'(i), 1'b1);
         if (!mem_stall) drive_mem(5'(i + 16), 32'h400 + 32'(i), 1'b1);
         else drive_mem(5'd31, 32'hDEAD_0002, 1'b0);
      end
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      @(posedge clk);
      #1;
      q_alu.delete();
      q_mem.delete();
      @(negedge clk);
      idle_inputs();
      chk("ovf_after_flush", 64'(cdb_overflow), 64'd1);

      // ---- async reset mid-burst ----
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_alu(5'(20 + i), 32'h500 + 32'(i), 1'b1);
         drive_mem(5'(24 + i), 32'h600 + 32'(i), 1'b1);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(cdb_ready), 64'd0);
      chk("arst_val", 64'(cdb_val), 64'd0);
      chk("arst_id", 64'(cdb_id), 64'd0);
      chk("arst_ovf", 64'(cdb_overflow), 64'd0);
      chk("arst_stall", 64'({alu_stall, mem_stall}), 64'd0);
      q_alu.delete();
      q_mem.delete();
      q_log.delete();
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("arst_no_replay", 64'(q_log.size()), 64'd0);
      drive_mem(5'd9, 32'h99, 1'b1);
      @(negedge clk);
      idle_inputs();
      wait_drain("post_arst");
      chk("post_arst_cnt", 64'(q_log.size()), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
